// File: rtl/usbfs_tx_phy_pkg.sv
// Shared definitions for the USB full-speed transmit PHY.
//   LINE_J / LINE_K / LINE_SE0 : bus states encoded as {dp, dn}
//   SYNC_BYTE                  : SYNC pattern, sent LSB first
//   tx_state_e                 : transmit sequencer states
//   line_cmd_e                 : per-bit command to the NRZI/stuffing stage
//   nrzi_toggle()              : J <-> K swap
package usbfsTxPkg;

    localparam logic [1:0] LINE_J    = 2'b10;
    localparam logic [1:0] LINE_K    = 2'b01;
    localparam logic [1:0] LINE_SE0  = 2'b00;
    localparam logic [7:0] SYNC_BYTE = 8'h80;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        DATA,
        EOP_SE0,
        EOP_J,
        GAP
    } tx_state_e;

    typedef enum logic [1:0] {
        LCMD_HOLD,  // keep the current line state
        LCMD_BIT,   // emit one NRZI bit (or the owed stuff bit)
        LCMD_SE0,   // drive single-ended zero
        LCMD_J      // drive idle J
    } line_cmd_e;

    function automatic logic [1:0] nrzi_toggle(input logic [1:0] line);
        return (line == LINE_J) ? LINE_K : LINE_J;
    endfunction

endpackage

// File: rtl/usbfs_tx_nrzistuff.sv
// NRZI encoder and bit stuffer for the USB FS transmitter.
// Owns the registered line state and the run-of-ones counter.
//   clk_48MHz, rst (sync, active-high), i_cg (clock-gate enable)
//   i_cmd             : command applied at this edge (HOLD/BIT/SE0/J)
//   i_bit             : data bit for LCMD_BIT (ignored while a stuff is owed)
//   o_line            : {dp, dn} drive value
//   o_stuff_pending   : next bit-time must be a stuffed 0
module usbfs_tx_nrzistuff
    import usbfsTxPkg::*;
#(
    parameter int STUFF_RUN = 6
) (
    input  logic       clk_48MHz,
    input  logic       rst,
    input  logic       i_cg,
    input  line_cmd_e  i_cmd,
    input  logic       i_bit,
    output logic [1:0] o_line,
    output logic       o_stuff_pending
);

    localparam int OW = $clog2(STUFF_RUN + 1);

    logic [OW-1:0] ones;

    assign o_stuff_pending = (ones == OW'(STUFF_RUN));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk_48MHz) begin
        if (rst) begin
            o_line <= LINE_J;
            ones   <= '0;
        end else if (i_cg) begin
            unique case (i_cmd)
                LCMD_BIT: begin
                    // A stuffed bit is a forced 0: it toggles like any 0.
                    if (o_stuff_pending || !i_bit) begin
                        o_line <= nrzi_toggle(o_line);
                        ones   <= '0;
                    end else begin
                        ones <= ones + OW'(1);
                    end
                end
                LCMD_SE0: begin
                    o_line <= LINE_SE0;
                    ones   <= '0;
                end
                LCMD_J: begin
                    o_line <= LINE_J;
                    ones   <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/usbfs_tx_phy.sv
// USB full-speed (12 Mb/s) line transmitter, 4 clk_48MHz cycles per bit.
// Takes a packet as a byte stream (valid/ready) and sends SYNC, NRZI-encoded
// bit-stuffed data (LSB first) and EOP onto the pad drivers.
//   clk_48MHz, rst (sync, active-high), i_cg (clock-gate enable, 0 = freeze)
//   i_data/i_valid/i_last, o_ready : byte stream, PID first, i_last on final byte
//   o_dp/o_dn/o_oe                 : pad drive values and output enable
//   o_busy                         : SYNC start through EOP end (and gap)
//   o_underflow                    : one-cycle pulse, stream starved mid-packet
// Build option: define USBFS_TX_IPGAP_EN to insert a 4 bit-time idle gap
// after EOP before the next packet may start.
module usbfs_tx_phy
    import usbfsTxPkg::*;
#(
    parameter int CLKS_PER_BIT = 4,
    parameter int STUFF_RUN    = 6
) (
    input  logic       clk_48MHz,
    input  logic       rst,
    input  logic       i_cg,
    input  logic [7:0] i_data,
    input  logic       i_valid,
    input  logic       i_last,
    output logic       o_ready,
    output logic       o_dp,
    output logic       o_dn,
    output logic       o_oe,
    output logic       o_busy,
    output logic       o_underflow
);

    tx_state_e  state, state_n;
    logic [1:0] cnt;
    logic [2:0] bit_idx, bit_idx_n;
    logic [7:0] shifter, shifter_n;
    logic [7:0] hold, hold_n;
    logic       flag, flag_n;
    logic       last_acc, last_acc_n;
    logic       uf_n;
    line_cmd_e  cmd;
    logic       cmd_bit;
    logic       stuff_pending;
    logic       bit_end;
    logic       take;

    assign bit_end = (state != IDLE) && (cnt == 2'(CLKS_PER_BIT - 1));

    assign o_ready = !rst && i_cg && !flag && !last_acc &&
                     (state == IDLE || state == SYNC || state == DATA);
    assign take    = i_valid && o_ready;

    assign o_oe   = (state == SYNC) || (state == DATA) ||
                    (state == EOP_SE0) || (state == EOP_J);
    assign o_busy = (state != IDLE);

    usbfs_tx_nrzistuff #(.STUFF_RUN(STUFF_RUN)) u_nrzistuff (
        .clk_48MHz       (clk_48MHz),
        .rst             (rst),
        .i_cg            (i_cg),
        .i_cmd           (cmd),
        .i_bit           (cmd_bit),
        .o_line          ({o_dp, o_dn}),
        .o_stuff_pending (stuff_pending)
    );

    // Every command issued here decides the line state for the bit-time that
    // starts after this edge.
    // NOTE: every output of this block gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        state_n    = state;
        bit_idx_n  = bit_idx;
        shifter_n  = shifter;
        hold_n     = hold;
        flag_n     = flag;
        last_acc_n = last_acc;
        uf_n       = 1'b0;
        cmd        = LCMD_HOLD;
        cmd_bit    = 1'b0;

        if (take) begin
            hold_n     = i_data;
            flag_n     = 1'b1;
            last_acc_n = i_last;
        end

        unique case (state)
            IDLE: begin
                if (take) begin
                    state_n   = SYNC;
                    bit_idx_n = 3'd0;
                    cmd       = LCMD_BIT;
                    cmd_bit   = SYNC_BYTE[0];
                end
            end
            SYNC: begin
                if (bit_end) begin
                    if (bit_idx != 3'd7) begin
                        bit_idx_n = bit_idx + 3'd1;
                        cmd       = LCMD_BIT;
                        cmd_bit   = SYNC_BYTE[bit_idx_n];
                    end else begin
                        state_n   = DATA;
                        bit_idx_n = 3'd0;
                        shifter_n = hold;
                        flag_n    = 1'b0;
                        cmd       = LCMD_BIT;
                        cmd_bit   = hold[0];
                    end
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (stuff_pending) begin
                        // Stuffed bit: shifter position does not move.
                        cmd = LCMD_BIT;
                    end else if (bit_idx != 3'd7) begin
                        bit_idx_n = bit_idx + 3'd1;
                        cmd       = LCMD_BIT;
                        cmd_bit   = shifter[bit_idx_n];
                    end else if (flag) begin
                        bit_idx_n = 3'd0;
                        shifter_n = hold;
                        flag_n    = 1'b0;
                        cmd       = LCMD_BIT;
                        cmd_bit   = hold[0];
                    end else if (take) begin
                        // Byte arriving exactly when needed bypasses the
                        // holding register, so it is not an underflow.
                        bit_idx_n = 3'd0;
                        shifter_n = i_data;
                        flag_n    = 1'b0;
                        cmd       = LCMD_BIT;
                        cmd_bit   = i_data[0];
                    end else begin
                        state_n   = EOP_SE0;
                        bit_idx_n = 3'd0;
                        cmd       = LCMD_SE0;
                        uf_n      = !last_acc;
                    end
                end
            end
            EOP_SE0: begin
                if (bit_end) begin
                    if (bit_idx == 3'd0) begin
                        bit_idx_n = 3'd1;
                    end else begin
                        state_n   = EOP_J;
                        bit_idx_n = 3'd0;
                        cmd       = LCMD_J;
                    end
                end
            end
            EOP_J: begin
                if (bit_end) begin
                    last_acc_n = 1'b0;
                    bit_idx_n  = 3'd0;
`ifdef USBFS_TX_IPGAP_EN
                    state_n    = GAP;
`else
                    state_n    = IDLE;
`endif
                end
            end
            GAP: begin
                if (bit_end) begin
                    if (bit_idx == 3'd3) state_n = IDLE;
                    else                 bit_idx_n = bit_idx + 3'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // NOTE: the holding and shift registers are reset along with the control
    // state so a packet aborted by rst never leaks stale data into the next.
    always_ff @(posedge clk_48MHz) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= 2'd0;
            bit_idx     <= 3'd0;
            shifter     <= 8'h00;
            hold        <= 8'h00;
            flag        <= 1'b0;
            last_acc    <= 1'b0;
            o_underflow <= 1'b0;
        end else if (i_cg) begin
            state       <= state_n;
            cnt         <= (state == IDLE) ? 2'd0 : cnt + 2'd1;
            bit_idx     <= bit_idx_n;
            shifter     <= shifter_n;
            hold        <= hold_n;
            flag        <= flag_n;
            last_acc    <= last_acc_n;
            o_underflow <= uf_n;
        end
    end

endmodule

// File: tb/tb_usbfs_tx_phy.sv
// Directed testbench for usbfs_tx_phy. Line states are captured once per
// bit-time while o_oe is high and compared against hand-derived strings:
// 'J', 'K', '0' (SE0).
module tb_usbfs_tx_phy;

    logic       clk_48MHz = 1'b0;
    logic       rst       = 1'b1;
    logic       i_cg      = 1'b1;
    logic [7:0] i_data    = 8'h00;
    logic       i_valid   = 1'b0;
    logic       i_last    = 1'b0;
    logic       o_ready, o_dp, o_dn, o_oe, o_busy, o_underflow;

    usbfs_tx_phy dut (
        .clk_48MHz   (clk_48MHz),
        .rst         (rst),
        .i_cg        (i_cg),
        .i_data      (i_data),
        .i_valid     (i_valid),
        .i_last      (i_last),
        .o_ready     (o_ready),
        .o_dp        (o_dp),
        .o_dn        (o_dn),
        .o_oe        (o_oe),
        .o_busy      (o_busy),
        .o_underflow (o_underflow)
    );

    always #10 clk_48MHz = ~clk_48MHz;

    int errors = 0;
    int checks = 0;

    // Packet to send
    logic [7:0] pkt [4];
    int         pkt_n;
    bit         pkt_has_last;

    // Results of the last run_pkt call
    string      seq;
    int         oe_hi, n_acc, rdy_hi, uf_at, uf_cnt;
    int         pre, pre_nrdy, pre_busy, hold_bad;
    logic [1:0] done_line;

    function automatic string line_char(input logic [1:0] l);
        case (l)
            2'b10:   return "J";
            2'b01:   return "K";
            2'b00:   return "0";
            default: return "X";
        endcase
    endfunction

    function automatic int longest_run(input string s);
        int best = 0;
        int run  = 0;
        for (int i = 0; i < s.len(); i++) begin
            if (s[i] == "0")                    run = 0;
            else if (i > 0 && s[i] == s[i-1])   run++;
            else                                run = 1;
            if (run > best) best = run;
        end
        return best;
    endfunction

    // Runs from the current negedge until o_oe falls after having risen.
    // cg_at/cg_len: gate the clock for cg_len edges once cg_at oe-cycles are seen.
    // rst_at: pulse rst for one edge once rst_at oe-cycles are seen (0 = never).
    task automatic run_pkt(input int cg_at, input int cg_len, input int rst_at);
        logic [1:0] samp [$];
        bit         started = 1'b0;
        bit         prev_cg = 1'b1;
        int         ptr     = 0;
        int         t       = 0;
        seq = ""; oe_hi = 0; n_acc = 0; rdy_hi = 0; uf_at = -1; uf_cnt = 0;
        pre = 0; pre_nrdy = 0; pre_busy = 0; hold_bad = 0; done_line = 2'bxx;
        while (1) begin
            if (t >= 600) begin
                errors++; checks++;
                $display("FAIL run_pkt_timeout: o_oe never completed a packet within %0d cycles", t);
                break;
            end
            if (o_oe === 1'b1) begin
                started = 1'b1;
                oe_hi++;
                if (prev_cg) samp.push_back({o_dp, o_dn});
                else if (samp.size() > 0 && samp[$] !== {o_dp, o_dn}) hold_bad++;
                if (o_ready === 1'b1) rdy_hi++;
            end else if (started) begin
                done_line = {o_dp, o_dn};
                break;
            end else begin
                pre++;
                if (o_ready !== 1'b1) pre_nrdy++;
                if (o_busy === 1'b1)  pre_busy++;
            end
            if (o_underflow === 1'b1) begin
                uf_cnt++;
                if (uf_at < 0) uf_at = oe_hi;
            end
            rst     = started && rst_at > 0 && oe_hi == rst_at;
            i_cg    = !(started && oe_hi >= cg_at && oe_hi < cg_at + cg_len);
            i_valid = (ptr < pkt_n);
            i_data  = (ptr < pkt_n) ? pkt[ptr] : 8'h00;
            i_last  = pkt_has_last && (ptr == pkt_n - 1);
            #1;
            if (i_valid && o_ready === 1'b1) begin
                ptr++;
                n_acc++;
            end
            prev_cg = i_cg;
            @(negedge clk_48MHz);
            t++;
        end
        rst = 1'b0; i_cg = 1'b1; i_valid = 1'b0; i_last = 1'b0;
        for (int k = 0; k < samp.size() / 4; k++) seq = {seq, line_char(samp[4*k])};
    endtask

    task automatic idle_wait();
        repeat (24) @(negedge clk_48MHz);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk_48MHz);
        checks++;
        if ({o_dp, o_dn, o_oe, o_ready, o_busy, o_underflow} !== 6'b100000) begin
            errors++;
            $display("FAIL reset_outputs: got dp,dn,oe,ready,busy,uf=%b want 100000",
                     {o_dp, o_dn, o_oe, o_ready, o_busy, o_underflow});
        end
        rst = 1'b0;
        #1;
        checks++;
        if (o_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: got %b want 1", o_ready);
        end
        @(negedge clk_48MHz);
    endtask

    task automatic test_zero_byte();
        idle_wait();
        pkt[0] = 8'h00; pkt_n = 1; pkt_has_last = 1'b1;
        run_pkt(0, 0, 0);
        checks++;
        if (seq != "KJKJKJKKJKJKJKJK00J") begin
            errors++; $display("FAIL zero_seq: got %s want KJKJKJKKJKJKJKJK00J", seq);
        end
        // 8 SYNC + 8 data + 3 EOP bit-times
        checks++;
        if (oe_hi != 76) begin errors++; $display("FAIL zero_oe_len: got %0d want 76", oe_hi); end
        checks++;
        if (n_acc != 1) begin errors++; $display("FAIL zero_accepts: got %0d want 1", n_acc); end
        checks++;
        if (rdy_hi != 0) begin errors++; $display("FAIL zero_ready_in_pkt: got %0d want 0", rdy_hi); end
    endtask

    task automatic test_all_ones();
        idle_wait();
        pkt[0] = 8'hFF; pkt_n = 1; pkt_has_last = 1'b1;
        run_pkt(0, 0, 0);
        checks++;
        if (seq != "KJKJKJKKKKKKKJJJJ00J") begin
            errors++; $display("FAIL ones_seq: got %s want KJKJKJKKKKKKKJJJJ00J", seq);
        end
        checks++;
        if (oe_hi != 80) begin errors++; $display("FAIL ones_oe_len: got %0d want 80", oe_hi); end
    endtask

    task automatic test_stuff_boundary();
        idle_wait();
        pkt[0] = 8'h3F; pkt[1] = 8'h00; pkt_n = 2; pkt_has_last = 1'b1;
        run_pkt(0, 0, 0);
        // SYNC's trailing 1 counts, so the stuff follows data bit 4
        checks++;
        if (seq != "KJKJKJKKKKKKKJJKJKJKJKJKJ00J") begin
            errors++; $display("FAIL stuff_seq: got %s want KJKJKJKKKKKKKJJKJKJKJKJKJ00J", seq);
        end
        checks++;
        if (oe_hi != 112) begin errors++; $display("FAIL stuff_oe_len: got %0d want 112", oe_hi); end
        checks++;
        if (longest_run(seq) > 7) begin
            errors++; $display("FAIL stuff_max_run: got %0d want <=7", longest_run(seq));
        end
        checks++;
        if (n_acc != 2) begin errors++; $display("FAIL stuff_accepts: got %0d want 2", n_acc); end
    endtask

    task automatic test_underflow();
        idle_wait();
        pkt[0] = 8'hC3; pkt_n = 1; pkt_has_last = 1'b0;
        run_pkt(0, 0, 0);
        checks++;
        if (seq != "KJKJKJKKKKJKJKKK00J") begin
            errors++; $display("FAIL uf_seq: got %s want KJKJKJKKKKJKJKKK00J", seq);
        end
        checks++;
        if (uf_at != 65) begin errors++; $display("FAIL uf_cycle: got %0d want 65", uf_at); end
        checks++;
        if (uf_cnt != 1) begin errors++; $display("FAIL uf_width: got %0d want 1", uf_cnt); end
        checks++;
        if (oe_hi != 76) begin errors++; $display("FAIL uf_oe_len: got %0d want 76", oe_hi); end
    endtask

    task automatic test_clock_gate();
        idle_wait();
        pkt[0] = 8'h00; pkt_n = 1; pkt_has_last = 1'b1;
        run_pkt(40, 7, 0);
        checks++;
        if (seq != "KJKJKJKKJKJKJKJK00J") begin
            errors++; $display("FAIL cg_seq: got %s want KJKJKJKKJKJKJKJK00J", seq);
        end
        checks++;
        if (oe_hi != 83) begin errors++; $display("FAIL cg_oe_len: got %0d want 83", oe_hi); end
        checks++;
        if (hold_bad != 0) begin errors++; $display("FAIL cg_hold: got %0d changes want 0", hold_bad); end
    endtask

    task automatic test_reset_mid();
        idle_wait();
        pkt[0] = 8'h00; pkt[1] = 8'h00; pkt_n = 2; pkt_has_last = 1'b1;
        run_pkt(0, 0, 30);
        checks++;
        if (oe_hi != 30) begin errors++; $display("FAIL rst_oe_len: got %0d want 30", oe_hi); end
        checks++;
        if (done_line !== 2'b10) begin
            errors++; $display("FAIL rst_line_j: got %b want 10", done_line);
        end
        #1;
        checks++;
        if (o_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_after: got %b want 1", o_ready); end
        checks++;
        if (o_busy !== 1'b0) begin errors++; $display("FAIL rst_busy_after: got %b want 0", o_busy); end
        @(negedge clk_48MHz);
    endtask

    task automatic test_back_to_back();
        idle_wait();
        pkt[0] = 8'h00; pkt_n = 1; pkt_has_last = 1'b1;
        run_pkt(0, 0, 0);
        pkt[0] = 8'hFF;
        run_pkt(0, 0, 0);
        checks++;
        if (seq != "KJKJKJKKKKKKKJJJJ00J") begin
            errors++; $display("FAIL b2b_seq: got %s want KJKJKJKKKKKKKJJJJ00J", seq);
        end
`ifdef USBFS_TX_IPGAP_EN
        checks++;
        if (pre != 17) begin errors++; $display("FAIL b2b_oe_low: got %0d want 17", pre); end
        checks++;
        if (pre_nrdy != 16) begin errors++; $display("FAIL b2b_ready_low: got %0d want 16", pre_nrdy); end
        checks++;
        if (pre_busy != 16) begin errors++; $display("FAIL b2b_gap_busy: got %0d want 16", pre_busy); end
`else
        // o_oe is low for a single cycle between packets
        checks++;
        if (pre != 1) begin errors++; $display("FAIL b2b_oe_low: got %0d want 1", pre); end
        checks++;
        if (pre_busy != 0) begin errors++; $display("FAIL b2b_idle_busy: got %0d want 0", pre_busy); end
`endif
    endtask

    initial begin
        test_reset();
        test_zero_byte();
        test_all_ones();
        test_stuff_boundary();
        test_underflow();
        test_clock_gate();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
